// File: rtl/mem_responder_if.sv
// mem_responder_if
// Initiator-side memory bus shared by the datapath FSMs and the memory responder.
//   mem_req       initiator -> responder  one access per cycle it is high
//   mem_write     initiator -> responder  1 = write, 0 = read (qualified by mem_req)
//   mem_addr      initiator -> responder  word address
//   mem_wdata     initiator -> responder  write data
//   mem_rdata_vld responder -> initiator  one-cycle pulse per returned read
//   mem_rdata     responder -> initiator  read data, held between pulses
interface mem_responder_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
) ();
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Single-port memory responder serving the initiator bus from an internal array.
// Writes land at the end of the request cycle; reads return in order after a
// fixed RD_LAT-cycle pipelined latency. After reset the array is cleared one
// word per cycle before any request is honoured.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        mem_responder_if slave modport (request in, read data out)
//   init_done  array clear finished, requests are honoured
//   err        sticky: [0] address out of range, [1] request before init_done
//   rd_cnt     accepted in-range reads, saturating at 0xFFFF
//   wr_cnt     accepted in-range writes, saturating at 0xFFFF
module mem_responder #(
  parameter int MEM_AW     = 16,
  parameter int MEM_DW     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  output logic                  init_done,
  output logic [1:0]            err,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state_q;
  logic [DEPTH_LOG2-1:0]   ptr_q;
  logic                    init_done_q;

  logic [MEM_DW-1:0]       mem_q [DEPTH];

  logic                    acc;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [MEM_DW-1:0]       mem_wdat;

  logic                    push_vld;
  logic [MEM_DW-1:0]       push_dat;
  logic [RD_LAT:0]         vld_sh;
  logic [MEM_DW-1:0]       dat_sh [RD_LAT+1];
  logic [RD_LAT-1:0]       vld_d;
  logic [RD_LAT-1:0]       vld_q;
  logic [MEM_DW-1:0]       dat_q [RD_LAT];

  logic [1:0]              err_d,    err_q;
  logic [15:0]             rd_cnt_d, rd_cnt_q;
  logic [15:0]             wr_cnt_d, wr_cnt_q;

  // Clear sequencer: walks ptr over every word, then serves requests until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == {DEPTH_LOG2{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Request decode. Upper address bits must be zero to hit the array.
  always_comb begin
    acc      = bus.mem_req && (state_q == ST_RUN);
    in_range = ((bus.mem_addr >> DEPTH_LOG2) == '0);
    idx      = bus.mem_addr[DEPTH_LOG2-1:0];

    // The clear pass owns the write port while in INIT.
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdat  = bus.mem_wdata;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdat  = '0;
    end else if (acc && bus.mem_write && in_range) begin
      mem_we = 1'b1;
    end

    // Out-of-range reads still return a (zero) beat so the initiator never stalls.
    push_vld = acc && !bus.mem_write;
    push_dat = in_range ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdat;
  end

  // Status: sticky errors and saturating access counters.
  always_comb begin
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (bus.mem_req && (state_q == ST_INIT)) err_d[1] = 1'b1;
    if (acc) begin
      if (!in_range)          err_d[0] = 1'b1;
      else if (bus.mem_write) wr_cnt_d = sat_inc(wr_cnt_q);
      else                    rd_cnt_d = sat_inc(rd_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read return pipeline: slot 0 captures the array at the end of the request
  // cycle, slot RD_LAT-1 is the output register.
  always_comb begin
    vld_sh    = {vld_q, push_vld};
    vld_d     = vld_sh[RD_LAT-1:0];
    dat_sh[0] = push_dat;
    for (int i = 0; i < RD_LAT; i++) dat_sh[i+1] = dat_q[i];
  end

  // Data slots only load under a valid beat, so the output holds between pulses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (vld_sh[i]) dat_q[i] <= dat_sh[i];
    end
    if (rst) begin
      vld_q            <= '0;
      dat_q[RD_LAT-1]  <= '0;
    end else begin
      vld_q            <= vld_d;
    end
  end

  assign bus.mem_rdata_vld = vld_q[RD_LAT-1];
  assign bus.mem_rdata     = dat_q[RD_LAT-1];
  assign init_done         = init_done_q;
  assign err               = err_q;
  assign rd_cnt            = rd_cnt_q;
  assign wr_cnt            = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DL    = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done;
  logic [1:0]  err;
  logic [15:0] rd_cnt, wr_cnt;

  mem_responder_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

  mem_responder #(.MEM_AW(AW), .MEM_DW(DW), .DEPTH_LOG2(DL), .RD_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .init_done(init_done),
    .err      (err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: plain array plus a queue of scheduled read returns.
  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  logic [DW-1:0] m_mem [DEPTH];
  ret_t          m_q [$];
  int            m_init = 0;
  logic [1:0]    m_err  = '0;
  int            m_rd   = 0;
  int            m_wr   = 0;
  logic [DW-1:0] m_last = '0;
  logic          m_vld  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, advance the model by the same cycle, then compare all outputs.
  task automatic step(input logic r, input logic req, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    ret_t t;
    rst = r; bus.mem_req = req; bus.mem_write = wr; bus.mem_addr = a; bus.mem_wdata = d;
    if (r) begin
      m_q.delete();
      m_init = 0; m_err = '0; m_rd = 0; m_wr = 0; m_last = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_init < DEPTH) begin
      if (req) m_err[1] = 1'b1;
      m_init++;
    end else if (req) begin
      if (a < DEPTH) begin
        if (wr) begin
          m_mem[a[DL-1:0]] = d;
          if (m_wr < 65535) m_wr++;
        end else begin
          t.due = cyc + LAT; t.data = m_mem[a[DL-1:0]];
          m_q.push_back(t);
          if (m_rd < 65535) m_rd++;
        end
      end else begin
        m_err[0] = 1'b1;
        if (!wr) begin
          t.due = cyc + LAT; t.data = '0;
          m_q.push_back(t);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    m_vld = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      t = m_q.pop_front();
      m_vld  = 1'b1;
      m_last = t.data;
    end
    chk("vld",       {31'd0, bus.mem_rdata_vld}, {31'd0, m_vld});
    chk("rdata",     bus.mem_rdata, m_last);
    chk("init_done", {31'd0, init_done}, {31'd0, (m_init >= DEPTH)});
    chk("err",       {30'd0, err}, {30'd0, m_err});
    chk("rd_cnt",    {16'd0, rd_cnt}, 32'(m_rd));
    chk("wr_cnt",    {16'd0, wr_cnt}, 32'(m_wr));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Directed vectors; exp_* are the outputs seen in the cycle after the vector.
  typedef struct {
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_vld;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic ev, input logic [DW-1:0] er);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = a; v.wdata = d; v.exp_vld = ev; v.exp_rdata = er;
    return v;
  endfunction

  vec_t tbl [29];

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int zeros;
    logic seen;
    // write/read-back, pipelined reads, read-then-write, out-of-range aliasing
    tbl[0]  = mk(1, 1, 16'd3,  32'hDEADBEEF, 0, 32'h0);
    tbl[1]  = mk(1, 0, 16'd3,  32'h0,        0, 32'h0);
    tbl[2]  = mk(0, 0, 16'd0,  32'h0,        0, 32'h0);
    tbl[3]  = mk(0, 0, 16'd0,  32'h0,        1, 32'hDEADBEEF);
    tbl[4]  = mk(1, 1, 16'd0,  32'hA0,       0, 32'hDEADBEEF);
    tbl[5]  = mk(1, 1, 16'd1,  32'hA1,       0, 32'hDEADBEEF);
    tbl[6]  = mk(1, 1, 16'd2,  32'hA2,       0, 32'hDEADBEEF);
    tbl[7]  = mk(1, 1, 16'd3,  32'hA3,       0, 32'hDEADBEEF);
    tbl[8]  = mk(1, 0, 16'd0,  32'h0,        0, 32'hDEADBEEF);
    tbl[9]  = mk(1, 0, 16'd1,  32'h0,        0, 32'hDEADBEEF);
    tbl[10] = mk(1, 0, 16'd2,  32'h0,        1, 32'hA0);
    tbl[11] = mk(1, 0, 16'd3,  32'h0,        1, 32'hA1);
    tbl[12] = mk(0, 0, 16'd0,  32'h0,        1, 32'hA2);
    tbl[13] = mk(0, 0, 16'd0,  32'h0,        1, 32'hA3);
    tbl[14] = mk(0, 0, 16'd0,  32'h0,        0, 32'hA3);
    tbl[15] = mk(1, 1, 16'd7,  32'h11,       0, 32'hA3);
    tbl[16] = mk(1, 0, 16'd7,  32'h0,        0, 32'hA3);
    tbl[17] = mk(1, 1, 16'd7,  32'h22,       0, 32'hA3);
    tbl[18] = mk(1, 0, 16'd7,  32'h0,        1, 32'h11);
    tbl[19] = mk(0, 0, 16'd0,  32'h0,        0, 32'h11);
    tbl[20] = mk(0, 0, 16'd0,  32'h0,        1, 32'h22);
    tbl[21] = mk(0, 0, 16'd0,  32'h0,        0, 32'h22);
    tbl[22] = mk(1, 1, 16'd16, 32'h55,       0, 32'h22);
    tbl[23] = mk(1, 0, 16'd16, 32'h0,        0, 32'h22);
    tbl[24] = mk(0, 0, 16'd0,  32'h0,        0, 32'h22);
    tbl[25] = mk(0, 0, 16'd0,  32'h0,        1, 32'h0);
    tbl[26] = mk(1, 0, 16'd0,  32'h0,        0, 32'h0);
    tbl[27] = mk(0, 0, 16'd0,  32'h0,        0, 32'h0);
    tbl[28] = mk(0, 0, 16'd0,  32'h0,        1, 32'hA0);

    bus.mem_req = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

    // Reset, then count INIT cycles.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    zeros = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (init_done) seen = 1'b1;
      else begin
        zeros++;
        idle();
      end
    end
    chk("init_seen", {31'd0, seen}, 32'd1);
    chk("init_len",  32'(zeros), 32'(DEPTH));

    // First read after INIT returns the cleared value.
    step(1'b0, 1'b1, 1'b0, 16'd5, '0);
    idle();
    idle();
    chk("init_rd_vld",  {31'd0, bus.mem_rdata_vld}, 32'd1);
    chk("init_rd_data", bus.mem_rdata, 32'h0);

    for (int i = 0; i < 29; i++) begin
      step(1'b0, tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_vld", i),   {31'd0, bus.mem_rdata_vld}, {31'd0, tbl[i].exp_vld});
      chk($sformatf("tbl%0d_rdata", i), bus.mem_rdata, tbl[i].exp_rdata);
    end
    chk("tbl_err",    {30'd0, err}, 32'd1);
    chk("tbl_wr_cnt", {16'd0, wr_cnt}, 32'd7);
    chk("tbl_rd_cnt", {16'd0, rd_cnt}, 32'd9);

    // Reset while two reads are in flight; no late pulse, array re-cleared.
    step(1'b0, 1'b1, 1'b1, 16'd9, 32'h77);
    step(1'b0, 1'b1, 1'b0, 16'd9, '0);
    step(1'b0, 1'b1, 1'b0, 16'd9, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step(1'b0, 1'b1, 1'b1, 16'd2, 32'h1234);
      else        idle();
      chk("rst_no_vld", {31'd0, bus.mem_rdata_vld}, 32'd0);
    end
    chk("init_req_err", {30'd0, err}, 32'd2);
    step(1'b0, 1'b1, 1'b0, 16'd9, '0);
    idle();
    idle();
    chk("rst_rd_vld",  {31'd0, bus.mem_rdata_vld}, 32'd1);
    chk("rst_rd_data", bus.mem_rdata, 32'h0);
    chk("rst_rd_cnt",  {16'd0, rd_cnt}, 32'd1);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 600; i++) begin
      logic r, q, w;
      r = ($urandom_range(0, 149) == 0);
      q = ($urandom_range(0, 9) < 7);
      w = $urandom_range(0, 1) == 1;
      step(r, q, w, 16'($urandom_range(0, 19)), $urandom);
    end
    for (int i = 0; i < LAT + 1; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
